// File: rtl/wbn_ram_if.sv
// Wishbone B3 classic bus bundle between a wbn master and the wbn_ram slave.
interface wbn_ram_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          cyc;
  logic          we;
  logic          stb;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, we, stb, adr, sel, dat_w,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, we, stb, adr, sel, dat_w,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wbn_ram.sv
// Wishbone B3 classic slave RAM: byte-lane writes, registered reads, WAIT wait
// states, err on out-of-range words and rty while hold is high at accept.
module wbn_ram #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  wbn_ram_if.slave  bus
);
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned OFF = $clog2(SW);
  localparam int unsigned DAW = $clog2(DEPTH);
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];

  logic [AW-1:0]   widx_c;
  logic [DAW-1:0]  midx_c;
  logic            req_c;
  logic            in_range_c;
  logic            access_c;

  // Decode and the single-cycle access strobe shared by FSM and memory.
  always_comb begin
    widx_c     = bus.adr >> OFF;
    midx_c     = widx_c[DAW-1:0];
    in_range_c = (widx_c >> DAW) == '0;
    req_c      = bus.cyc & bus.stb;
    access_c   = 1'b0;
    if (rst && req_c) begin
      case (state)
        S_IDLE:  access_c = !hold && in_range_c && (WAIT == 0);
        S_WAIT:  access_c = (cnt == '0);
        default: access_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rty   <= 1'b0;
      bus.dat_r <= '0;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      bus.rty <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            state <= S_RESP;
            if (hold) begin
              bus.rty <= 1'b1;
            end else if (!in_range_c) begin
              bus.err <= 1'b1;
            end else if (access_c) begin
              bus.ack <= 1'b1;
            end else begin
              cnt   <= CW'(WAIT - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req_c) begin
            state <= S_IDLE;
          end else if (access_c) begin
            bus.ack <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Response lasts one cycle; a request still on the bus here is ignored.
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (access_c && !bus.we) bus.dat_r <= mem[midx_c];
    end
  end

  // Storage is not reset; writes honour the byte selects.
  always_ff @(posedge clk) begin
    if (access_c && bus.we) begin
      for (int k = 0; k < int'(SW); k++) begin
        if (bus.sel[k]) mem[midx_c][8*k +: 8] <= bus.dat_w[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wbn_ram.sv
// Directed bench for wbn_ram: three instances with WAIT=0, 2 and 3 share one master.
module tb_wbn_ram;
  logic        clk;
  logic        rst;
  logic        hold;
  logic        cyc_m, stb_m, we_m;
  logic [31:0] adr_m;
  logic [3:0]  sel_m;
  logic [31:0] dat_m;
  int          tgt;
  int          errors = 0;
  int          checks = 0;

  wbn_ram_if #(.AW(32), .DW(32)) b0 ();
  wbn_ram_if #(.AW(32), .DW(32)) b2 ();
  wbn_ram_if #(.AW(32), .DW(32)) b3 ();

  wbn_ram #(.AW(32), .DW(32), .DEPTH(256), .WAIT(0)) u0 (.clk(clk), .rst(rst), .hold(hold), .bus(b0));
  wbn_ram #(.AW(32), .DW(32), .DEPTH(256), .WAIT(2)) u2 (.clk(clk), .rst(rst), .hold(hold), .bus(b2));
  wbn_ram #(.AW(32), .DW(32), .DEPTH(256), .WAIT(3)) u3 (.clk(clk), .rst(rst), .hold(hold), .bus(b3));

  assign b0.cyc = cyc_m && (tgt == 0);
  assign b0.stb = stb_m && (tgt == 0);
  assign b2.cyc = cyc_m && (tgt == 2);
  assign b2.stb = stb_m && (tgt == 2);
  assign b3.cyc = cyc_m && (tgt == 3);
  assign b3.stb = stb_m && (tgt == 3);
  assign b0.we = we_m;  assign b0.adr = adr_m; assign b0.sel = sel_m; assign b0.dat_w = dat_m;
  assign b2.we = we_m;  assign b2.adr = adr_m; assign b2.sel = sel_m; assign b2.dat_w = dat_m;
  assign b3.we = we_m;  assign b3.adr = adr_m; assign b3.sel = sel_m; assign b3.dat_w = dat_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rsp(input int t);
    case (t)
      0:       rsp = {b0.ack, b0.err, b0.rty};
      2:       rsp = {b2.ack, b2.err, b2.rty};
      default: rsp = {b3.ack, b3.err, b3.rty};
    endcase
  endfunction

  function automatic logic [31:0] rd(input int t);
    case (t)
      0:       rd = b0.dat_r;
      2:       rd = b2.dat_r;
      default: rd = b3.dat_r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int t, input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    tgt = t; we_m = w; adr_m = a; sel_m = s; dat_m = d; cyc_m = 1'b1; stb_m = 1'b1;
  endtask

  task automatic idle_bus();
    cyc_m = 1'b0; stb_m = 1'b0;
  endtask

  // One transfer; lat=1 means the response came on the accept edge, 0 means none within budget.
  task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [2:0] r, output int lat, output logic [2:0] after);
    drive(t, w, a, s, d);
    r = 3'b000; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp(t) != 3'b000) begin r = rsp(t); lat = i; break; end
    end
    idle_bus();
    tick();
    after = rsp(t);
  endtask

  task automatic test_reset();
    logic [2:0] r, af; int lat;
    rst = 1'b0; hold = 1'b0; idle_bus(); tgt = 0;
    tick(); tick();
    rst = 1'b1; tick();
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_dat_r got=%h exp=%h", rd(0), 32'h0); end
    xfer(0, 1'b1, 32'h30, 4'hF, 32'h12345678, r, lat, af);
    xfer(0, 1'b0, 32'h30, 4'hF, 32'h0, r, lat, af);
    checks++; if (rd(0) !== 32'h12345678) begin errors++; $display("FAIL reset_pre_read got=%h exp=%h", rd(0), 32'h12345678); end
    rst = 1'b0;
    drive(0, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({rsp(0), rsp(2), rsp(3)} !== 9'h0) begin errors++; $display("FAIL reset_resp got=%b exp=0", {rsp(0), rsp(2), rsp(3)}); end
      checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_clear got=%h exp=%h", rd(0), 32'h0); end
    end
    idle_bus(); rst = 1'b1; tick();
    xfer(0, 1'b0, 32'h30, 4'hF, 32'h0, r, lat, af);
    checks++; if (rd(0) !== 32'h12345678) begin errors++; $display("FAIL reset_nowrite got=%h exp=%h", rd(0), 32'h12345678); end
  endtask

  task automatic test_wait2();
    logic [2:0] r, af; int lat;
    xfer(2, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, r, lat, af);
    checks++; if ({r, af} !== 6'b100_000 || lat != 3) begin errors++; $display("FAIL wait2_write got=%b/%b lat=%0d exp=100/000 lat=3", r, af, lat); end
    xfer(2, 1'b0, 32'h10, 4'h0, 32'h0, r, lat, af);
    checks++; if ({r, af} !== 6'b100_000 || lat != 3) begin errors++; $display("FAIL wait2_read got=%b/%b lat=%0d exp=100/000 lat=3", r, af, lat); end
    checks++; if (rd(2) !== 32'hDEADBEEF) begin errors++; $display("FAIL wait2_data got=%h exp=%h", rd(2), 32'hDEADBEEF); end
  endtask

  task automatic test_byte_lanes();
    logic [2:0] r, af; int lat;
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, r, lat, af);
    checks++; if (r !== 3'b100 || lat != 1) begin errors++; $display("FAIL lanes_w1 got=%b lat=%0d exp=100 lat=1", r, lat); end
    xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, r, lat, af);
    checks++; if (r !== 3'b100 || lat != 1) begin errors++; $display("FAIL lanes_w2 got=%b lat=%0d exp=100 lat=1", r, lat); end
    xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(0) !== 32'h11BB33DD || lat != 1) begin errors++; $display("FAIL lanes_read got=%h lat=%0d exp=%h lat=1", rd(0), lat, 32'h11BB33DD); end
  endtask

  task automatic test_range();
    logic [2:0] r, af; int lat;
    xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, r, lat, af);
    xfer(0, 1'b1, 32'h3FC, 4'hF, 32'h0BADCAFE, r, lat, af);
    checks++; if (r !== 3'b100) begin errors++; $display("FAIL range_top_write got=%b exp=100", r); end
    xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, r, lat, af);
    xfer(0, 1'b1, 32'h400, 4'hF, 32'h99999999, r, lat, af);
    checks++; if ({r, af} !== 6'b010_000 || lat != 1) begin errors++; $display("FAIL range_err got=%b/%b lat=%0d exp=010/000 lat=1", r, af, lat); end
    xfer(0, 1'b0, 32'h403, 4'h0, 32'h0, r, lat, af);
    checks++; if (r !== 3'b010 || rd(0) !== 32'h11BB33DD) begin errors++; $display("FAIL range_err_read got=%b %h exp=010 %h", r, rd(0), 32'h11BB33DD); end
    xfer(0, 1'b0, 32'h0, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(0) !== 32'hCAFEF00D) begin errors++; $display("FAIL range_noalias got=%h exp=%h", rd(0), 32'hCAFEF00D); end
    xfer(0, 1'b0, 32'h3FD, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(0) !== 32'h0BADCAFE) begin errors++; $display("FAIL range_top_read got=%h exp=%h", rd(0), 32'h0BADCAFE); end
  endtask

  task automatic test_priority();
    logic [2:0] r, af; int lat;
    hold = 1'b1;
    xfer(2, 1'b1, 32'h400, 4'hF, 32'h0, r, lat, af);
    checks++; if ({r, af} !== 6'b001_000 || lat != 1) begin errors++; $display("FAIL prio_hold_oor got=%b/%b lat=%0d exp=001/000 lat=1", r, af, lat); end
    xfer(2, 1'b1, 32'h10, 4'hF, 32'h0, r, lat, af);
    checks++; if (r !== 3'b001 || lat != 1) begin errors++; $display("FAIL prio_hold_valid got=%b lat=%0d exp=001 lat=1", r, lat); end
    hold = 1'b0;
    xfer(2, 1'b0, 32'h10, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(2) !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_nowrite got=%h exp=%h", rd(2), 32'hDEADBEEF); end
    drive(2, 1'b1, 32'h14, 4'hF, 32'h600DF00D);
    tick();
    checks++; if (rsp(2) !== 3'b000) begin errors++; $display("FAIL prio_accept got=%b exp=000", rsp(2)); end
    hold = 1'b1;
    tick();
    checks++; if (rsp(2) !== 3'b000) begin errors++; $display("FAIL prio_wait got=%b exp=000", rsp(2)); end
    tick();
    checks++; if (rsp(2) !== 3'b100) begin errors++; $display("FAIL prio_hold_midwait got=%b exp=100", rsp(2)); end
    idle_bus(); hold = 1'b0; tick();
    xfer(2, 1'b0, 32'h14, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(2) !== 32'h600DF00D) begin errors++; $display("FAIL prio_midwait_data got=%h exp=%h", rd(2), 32'h600DF00D); end
  endtask

  task automatic test_abort();
    logic [2:0] r, af; int lat; logic seen;
    xfer(3, 1'b1, 32'h40, 4'hF, 32'h11111111, r, lat, af);
    checks++; if (r !== 3'b100 || lat != 4) begin errors++; $display("FAIL abort_setup got=%b lat=%0d exp=100 lat=4", r, lat); end
    xfer(3, 1'b0, 32'h40, 4'h0, 32'h0, r, lat, af);
    drive(3, 1'b1, 32'h40, 4'hF, 32'h22222222);
    tick(); idle_bus();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp(3) != 3'b000) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_cyc got=1 exp=0"); end
    xfer(3, 1'b0, 32'h40, 4'h0, 32'h0, r, lat, af);
    checks++; if (rd(3) !== 32'h11111111) begin errors++; $display("FAIL abort_cyc_mem got=%h exp=%h", rd(3), 32'h11111111); end
    drive(3, 1'b1, 32'h40, 4'hF, 32'h33333333);
    tick();
    rst = 1'b0; idle_bus(); tick();
    checks++; if (rsp(3) !== 3'b000 || rd(3) !== 32'h0) begin errors++; $display("FAIL abort_rst got=%b %h exp=000 0", rsp(3), rd(3)); end
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (rsp(3) != 3'b000) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_rst_resp got=1 exp=0"); end
    xfer(3, 1'b0, 32'h40, 4'h0, 32'h0, r, lat, af);
    checks++; if (r !== 3'b100 || lat != 4 || rd(3) !== 32'h11111111) begin errors++; $display("FAIL abort_rst_next got=%b lat=%0d %h exp=100 lat=4 %h", r, lat, rd(3), 32'h11111111); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b0, 32'h20, 4'h0, 32'h0);
    tick();
    checks++; if (rsp(0) !== 3'b100 || rd(0) !== 32'h11BB33DD) begin errors++; $display("FAIL b2b_first got=%b %h exp=100 %h", rsp(0), rd(0), 32'h11BB33DD); end
    tick();
    checks++; if (rsp(0) !== 3'b000) begin errors++; $display("FAIL b2b_gap got=%b exp=000", rsp(0)); end
    tick();
    checks++; if (rsp(0) !== 3'b100) begin errors++; $display("FAIL b2b_second got=%b exp=100", rsp(0)); end
    idle_bus(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hold = 1'b0; tgt = 0;
    cyc_m = 1'b0; stb_m = 1'b0; we_m = 1'b0; adr_m = '0; sel_m = '0; dat_m = '0;
    test_reset();
    test_wait2();
    test_byte_lanes();
    test_range();
    test_priority();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
